// File: rtl/leaf_stream_stage.sv
// Leaf streaming stage: buffers a valid/ready byte stream in a DEPTH-entry
// FIFO and forwards it downstream unchanged. On the input side it also
// accumulates a per-packet checksum and counts completed packets.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_valid/in_ready      upstream handshake; in_data/in_last carry the beat
//   out_valid/out_ready    downstream handshake; out_data/out_last show the FIFO head
//   sum_valid, sum_value   one-cycle pulse with the checksum of a completed packet
//   pkt_count              packets accepted since reset (wraps at 16 bits)
//   level                  current FIFO occupancy
//   id_o                   constant instance identifier
module leaf_stream_stage #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SUM_W   = 16,
  parameter logic [7:0]  INST_ID = 8'd0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       sum_valid,
  output logic [SUM_W-1:0]           sum_value,
  output logic [15:0]                pkt_count,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 id_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic              mem_last_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     count_q, count_d;
  logic              rst_q;
  logic              full, empty, push, pop;

  // Checksum FSM state
  state_t            state_q, state_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  sum_next;
  logic              sum_valid_q, sum_valid_d;
  logic [SUM_W-1:0]  sum_value_q, sum_value_d;
  logic [15:0]       pkt_count_q, pkt_count_d;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);

  // Ready depends only on registered state, never on out_ready, so a pop
  // while full does not open the input in the same cycle.
  assign in_ready  = !full && !rst_q;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = mem_data_q[rptr_q];
  assign out_last  = mem_last_q[rptr_q];
  assign level     = count_q;
  assign id_o      = INST_ID;

  assign sum_valid = sum_valid_q;
  assign sum_value = sum_value_q;
  assign pkt_count = pkt_count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + LW'(1);
    end else if (pop && !push) begin
      count_d = count_q - LW'(1);
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wptr_q] <= in_data;
      mem_last_q[wptr_q] <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q   <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      rst_q   <= 1'b0;
      count_q <= count_d;
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
    end
  end

  // IDLE starts from zero so a first beat loads in_data directly.
  assign sum_next = ((state_q == IN_PKT) ? acc_q : '0) + SUM_W'(in_data);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_valid_d = 1'b0;
    sum_value_d = sum_value_q;
    pkt_count_d = pkt_count_q;
    if (push) begin
      if (in_last) begin
        sum_valid_d = 1'b1;
        sum_value_d = sum_next;
        pkt_count_d = pkt_count_q + 16'd1;
        state_d     = IDLE;
      end else begin
        acc_d   = sum_next;
        state_d = IN_PKT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_value_q <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_valid_q <= sum_valid_d;
      sum_value_q <= sum_value_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_leaf_stream_stage.sv
module tb_leaf_stream_stage;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_last, sum_valid;
  logic [7:0]  out_data, id_o;
  logic [15:0] sum_value, pkt_count;
  logic [2:0]  level;

  logic        in_ready8, out_valid8, out_last8, sum_valid8;
  logic [7:0]  out_data8, id8, sum_value8;
  logic [15:0] pkt_count8;
  logic [2:0]  level8;

  always #5 clk = ~clk;

  leaf_stream_stage #(.DATA_W(8), .DEPTH(DEPTH), .SUM_W(16), .INST_ID(8'h5A)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sum_valid(sum_valid), .sum_value(sum_value), .pkt_count(pkt_count),
    .level(level), .id_o(id_o)
  );

  // Narrow-checksum instance sharing the same stimulus to exercise wrap.
  leaf_stream_stage #(.DATA_W(8), .DEPTH(DEPTH), .SUM_W(8), .INST_ID(8'h03)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid8),
    .out_ready(out_ready), .out_data(out_data8), .out_last(out_last8),
    .sum_valid(sum_valid8), .sum_value(sum_value8), .pkt_count(pkt_count8),
    .level(level8), .id_o(id8)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { logic [7:0] data; logic last; } beat_t;
  typedef struct { int unsigned value; int unsigned due; } sum_t;
  beat_t       data_q[$];
  sum_t        sum_q[$];
  int unsigned exp_level = 0;
  int unsigned cur_sum   = 0;
  logic [15:0] exp_pkt   = '0;
  logic        rst_prev  = 1'b1;
  int unsigned cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Input-side monitor: checks occupancy/handshake flags, then records
  // accepted beats into the scoreboard and the checksum model.
  always @(negedge clk) begin
    logic exp_rdy, push_m, pop_m;
    exp_rdy = (exp_level < DEPTH) && !rst_prev;
    chk("level", level, exp_level);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_level != 0);
    chk("pkt_count", pkt_count, exp_pkt);
    chk("id", id_o, 8'h5A);
    chk("id8", id8, 8'h03);
    chk("in_ready8", in_ready8, exp_rdy);
    chk("level8", level8, exp_level);
    push_m = in_valid && exp_rdy;
    pop_m  = out_ready && (exp_level != 0);
    if (rst) begin
      data_q.delete();
      sum_q.delete();
      exp_level = 0;
      cur_sum   = 0;
      exp_pkt   = '0;
    end else begin
      if (push_m) begin
        data_q.push_back('{data: in_data, last: in_last});
        cur_sum += in_data;
        if (in_last) begin
          sum_q.push_back('{value: cur_sum % 65536, due: cyc + 1});
          cur_sum = 0;
          exp_pkt = exp_pkt + 16'd1;
        end
      end
      exp_level = exp_level + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    end
    rst_prev = rst;
  end

  // Output-side monitor: pops the scoreboard whenever the DUT hands a beat
  // downstream or reports a checksum.
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev  = '0;
  logic       last_prev  = 1'b0;
  always @(negedge clk) begin
    beat_t b;
    sum_t  s;
    if (stall_prev) begin
      chk("hold_data", out_data, data_prev);
      chk("hold_last", out_last, last_prev);
    end
    if (out_valid && out_ready && !rst) begin
      if (data_q.size() == 0) begin
        chk("out_spurious", out_valid, 1'b0);
      end else begin
        b = data_q.pop_front();
        chk("out_data", out_data, b.data);
        chk("out_last", out_last, b.last);
        chk("out_data8", out_data8, b.data);
      end
    end
    if (sum_q.size() != 0 && sum_q[0].due == cyc) begin
      s = sum_q.pop_front();
      chk("sum_valid", sum_valid, 1'b1);
      chk("sum_value", sum_value, s.value);
      chk("sum_valid8", sum_valid8, 1'b1);
      chk("sum_value8", sum_value8, s.value % 256);
    end else begin
      chk("sum_idle", sum_valid, 1'b0);
      chk("sum_idle8", sum_valid8, 1'b0);
    end
    stall_prev = out_valid && !out_ready && !rst;
    data_prev  = out_data;
    last_prev  = out_last;
  end

  task automatic send(input logic [7:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    chk("accept", acc, 1'b1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sum_value", sum_value, 16'h0000);
    chk("rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Three-beat packet
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    idle(4);

    // Fill to full with no drain, then release
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h45;
    in_last  = 1'b1;
    idle(3);
    @(negedge clk);
    chk("full_level", level, 3'd4);
    chk("full_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h45, 1'b1);
    idle(6);

    // Single-beat packet and narrow-checksum wrap packet
    send(8'hAB, 1'b1);
    idle(2);
    send(8'hF0, 1'b0);
    send(8'h20, 1'b1);
    idle(4);

    // Packet in flight discarded by reset
    out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_level", level, 3'd0);
    chk("rst2_sum_value", sum_value, 16'h0000);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h05, 1'b1);
    idle(3);

    // Steady push/pop at level 2 across pointer wrap
    out_ready = 1'b0;
    send(8'h70, 1'b0);
    send(8'h71, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(8'h72 + 8'(i), i == 9);
    idle(4);

    // Random traffic with random backpressure
    fork
      begin
        for (int p = 0; p < 60; p++) begin
          int unsigned len;
          len = $urandom_range(1, 5);
          for (int k = 0; k < int'(len); k++) begin
            send(8'($urandom), k == int'(len) - 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          end
        end
      end
      begin
        for (int c = 0; c < 600; c++) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    idle(20);
    @(negedge clk);
    chk("drain_data", data_q.size(), 0);
    chk("drain_sum", sum_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaf_stream_stage.md
Name: leaf_stream_stage

Overview:
- Leaf-level streaming stage instantiated beneath the generated sub-hierarchy modules, one per leaf instance.
- Accepts a valid/ready byte stream with packet delimiter and buffers it in a DEPTH-entry FIFO.
- Forwards the stream downstream unchanged.
- Accumulates a per-packet checksum and a packet counter, so each leaf carries real sequential state for hierarchy and elaboration testing.

Parameters:
- DATA_W, 8, width of the data beat.
- DEPTH, 4, FIFO entries. Power of two, minimum 2.
- SUM_W, 16, checksum accumulator width. Must be at least DATA_W.
- INST_ID, 0, constant identifier driven on id_o.

Ports:
- clk  input  1  single clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  DATA_W  upstream beat data.
- in_last  input  1  final beat of a packet.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts the head.
- out_data  output  DATA_W  FIFO head data.
- out_last  output  1  FIFO head last flag.
- sum_valid  output  1  one-cycle pulse when a packet checksum completes.
- sum_value  output  SUM_W  completed packet checksum.
- pkt_count  output  16  packets accepted since reset; wraps.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.
- id_o  output  8  constant INST_ID.

Behaviour:
- Reset is synchronous: on a clk edge with rst=1, all state clears.
  - FIFO becomes empty; read and write pointers return to 0.
  - level=0, out_valid=0, in_ready=0 during the reset cycle, then 1 from the first cycle after rst falls.
  - sum_valid=0, sum_value=0, pkt_count=0, and the FSM returns to IDLE.
  - A packet in flight when reset is asserted is discarded entirely, with no sum pulse.
- Push and pop:
  - push = in_valid & in_ready, where in_ready = !full & !rst_q. rst_q is a one-cycle registered copy of rst.
  - pop = out_valid & out_ready, where out_valid = !empty.
  - Push and pop in the same cycle are both permitted whenever the FIFO is neither full nor empty. level is then unchanged.
  - When full, in_ready=0 even if a pop occurs in that cycle (no combinational ready path from out_ready).
  - When empty there is no pass-through: minimum latency is 1 cycle from push to out_valid.
- Pointers wrap modulo DEPTH. full is asserted when level==DEPTH; empty when level==0.
- out_data and out_last are driven from the head entry. They are held stable while out_valid=1 and out_ready=0.
- Checksum FSM runs on the input side only:
  - IDLE: on push with in_last=0, acc <= in_data zero-extended; go to IN_PKT.
  - IDLE: on push with in_last=1 (single-beat packet), pulse sum_valid with sum_value = in_data; stay in IDLE.
  - IN_PKT: on push, acc <= acc + in_data, modulo 2^SUM_W (wraps, no saturation).
  - IN_PKT: if in_last is also set on that push, sum_value <= acc + in_data and sum_valid pulses for one cycle; return to IDLE.
- sum_valid and sum_value are registered, asserted the cycle after the last-beat push. sum_value holds until the next completion.
- pkt_count increments on every last-beat push and wraps from 0xFFFF to 0.
- Back-to-back packets with no idle cycle between them are supported. A push in IDLE in the cycle after a completion starts a new accumulation.
- Cycles with no push leave all FSM state unchanged.

Test Plan:
- Reset, then push 0x10, 0x20, 0x30 (last) with out_ready=1 → out beats 0x10/0x20/0x30 in order, out_last only on 0x30. sum_valid pulses once with sum_value=0x0060; pkt_count=1.
- out_ready=0, push 5 beats → 4 accepted, level=4, in_ready=0 on the 5th cycle. Raise out_ready → beats drain in order and in_ready returns 1 the cycle after the first pop.
- Single-beat packet 0xAB (last) → sum_value=0x00AB the next cycle; FSM stays in IDLE.
- SUM_W=8 override, packet 0xF0, 0x20 (last) → sum_value=0x10 (wrap).
- Push 0x01, 0x02, then assert rst for 1 cycle → level=0, no sum_valid. A subsequent packet 0x05 (last) gives sum_value=0x0005 and pkt_count=1.
- Continuous push and pop at level=2 for 10 cycles → level constant at 2; data order preserved across pointer wrap.
